// File: rtl/qam_pkg.sv
// qam_pkg
// Shared definitions for the QAM modulator and demodulator blocks so that the
// constellation mapping and bit order live in exactly one place.
//   - qam_mode_e       : mode encodings carried on the 3-bit qam field
//   - bits_per_symbol  : number of payload bits one symbol carries
//   - decode_mode      : maps a raw qam field to a mode (illegal -> BPSK)
//   - is_legal_mode    : true for the three supported encodings
//   - level/threshold constants and the Gray bit positions inside a slice
package qam_pkg;

  typedef enum logic [1:0] {
    QAM_BPSK = 2'd0,
    QAM_QPSK = 2'd1,
    QAM_16   = 2'd2
  } qam_mode_e;

  // 16-QAM amplitude levels and the decision threshold halfway between them.
  localparam int QAM16_LEVEL_INNER = 8192;
  localparam int QAM16_LEVEL_OUTER = 24576;
  localparam int QAM16_THRESH      = 16384;

  // Gray bit positions inside a 4-bit 16-QAM slice: {Q_mag, Q_sign, I_mag, I_sign}.
  // Per axis this yields -3A=11, -1A=10, +1A=00, +3A=01 written as {sign, mag}.
  localparam int GRAY_I_SIGN = 0;
  localparam int GRAY_I_MAG  = 1;
  localparam int GRAY_Q_SIGN = 2;
  localparam int GRAY_Q_MAG  = 3;

  localparam int WORD_W = 32;

  function automatic logic [5:0] bits_per_symbol(input qam_mode_e mode);
    case (mode)
      QAM_QPSK: return 6'd2;
      QAM_16:   return 6'd4;
      default:  return 6'd1;
    endcase
  endfunction

  function automatic logic is_legal_mode(input logic [2:0] qam);
    return (qam == 3'd0) || (qam == 3'd1) || (qam == 3'd2);
  endfunction

  // Illegal encodings fall back to BPSK so the word still has a defined shape.
  function automatic qam_mode_e decode_mode(input logic [2:0] qam);
    case (qam)
      3'd1:    return QAM_QPSK;
      3'd2:    return QAM_16;
      default: return QAM_BPSK;
    endcase
  endfunction

endpackage

// File: rtl/qam_demod_packer_if.sv
// qam_demod_packer_if
// Bundles the symbol-side and word-side handshakes of the demodulator packer.
//   signal_in  [31:0] received symbol {I[31:16], Q[15:0]}, signed
//   qam        [2:0]  mode request (0=BPSK, 1=QPSK, 2=16-QAM)
//   valid_in          symbol valid
//   ready_out         packer can accept a symbol
//   signal_out [31:0] packed word
//   valid_out         word valid
//   ready_in          downstream accepts word
//   error             sticky error flag
// master: the side that supplies symbols and consumes words.
// slave : the packer itself.
interface qam_demod_packer_if;

  logic [31:0] signal_in;
  logic [2:0]  qam;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] signal_out;
  logic        valid_out;
  logic        ready_in;
  logic        error;

  modport master (
    output signal_in, qam, valid_in, ready_in,
    input  ready_out, signal_out, valid_out, error
  );

  modport slave (
    input  signal_in, qam, valid_in, ready_in,
    output ready_out, signal_out, valid_out, error
  );

endinterface

// File: rtl/qam_slicer.sv
// qam_slicer
// Combinational hard-decision slicer for one received I/Q symbol.
//   i_sample   [SAMPLE_W-1:0] in  signed in-phase sample
//   q_sample   [SAMPLE_W-1:0] in  signed quadrature sample
//   mode       qam_mode_e     in  constellation to slice against
//   slice_bits [3:0]          out recovered bits, LSB = first bit on the wire
// Unused upper bits are zero for BPSK and QPSK.
module qam_slicer
  import qam_pkg::*;
#(
  parameter int SAMPLE_W     = 16,
  parameter int SLICE_THRESH = QAM16_THRESH
) (
  input  logic signed [SAMPLE_W-1:0] i_sample,
  input  logic signed [SAMPLE_W-1:0] q_sample,
  input  qam_mode_e                  mode,
  output logic        [3:0]          slice_bits
);

  // Thresholds held at sample width so the comparisons stay signed and
  // equal-width; the magnitude test uses two compares instead of abs() so
  // the most negative sample cannot overflow.
  localparam logic signed [SAMPLE_W-1:0] THRESH_POS = SAMPLE_W'(SLICE_THRESH);
  localparam logic signed [SAMPLE_W-1:0] THRESH_NEG = SAMPLE_W'(-SLICE_THRESH);

  logic i_sign;
  logic q_sign;
  logic i_mag;
  logic q_mag;

  always_comb begin
    i_sign = i_sample[SAMPLE_W-1];
    q_sign = q_sample[SAMPLE_W-1];
    i_mag  = (i_sample >= THRESH_POS) || (i_sample <= THRESH_NEG);
    q_mag  = (q_sample >= THRESH_POS) || (q_sample <= THRESH_NEG);

    slice_bits = 4'b0000;
    case (mode)
      QAM_QPSK: begin
        slice_bits[0] = i_sign;
        slice_bits[1] = q_sign;
      end
      QAM_16: begin
        slice_bits[GRAY_I_SIGN] = i_sign;
        slice_bits[GRAY_I_MAG]  = i_mag;
        slice_bits[GRAY_Q_SIGN] = q_sign;
        slice_bits[GRAY_Q_MAG]  = q_mag;
      end
      default: begin
        slice_bits[0] = i_sign;
      end
    endcase
  end

endmodule

// File: rtl/qam_demod_packer.sv
// qam_demod_packer
// Receive-side packer: slices one I/Q symbol per accepted handshake and packs
// the recovered bits LSB-first into 32-bit words, so a modulator word in comes
// back unchanged on an ideal channel.
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of qam_demod_packer_if (symbol in, word out, error)
// A finished word is registered on the edge of the accept that completes it
// and is held until the consumer takes it.
module qam_demod_packer
  import qam_pkg::*;
#(
  parameter int SAMPLE_W     = 16,
  parameter int SLICE_THRESH = QAM16_THRESH
) (
  input  logic               clk,
  input  logic               rst_n,
  qam_demod_packer_if.slave  bus
);

  logic [WORD_W-1:0] acc;
  logic [5:0]        count;
  qam_mode_e         mode_q;
  logic [WORD_W-1:0] word_q;
  logic              word_valid_q;
  logic              error_q;

  logic              accept;
  logic              word_start;
  qam_mode_e         eff_mode;
  logic [5:0]        n_bits;
  logic [5:0]        count_next;
  logic [WORD_W-1:0] acc_next;
  logic              word_done;
  logic              drain;
  logic              mode_conflict;
  logic              illegal_start;
  logic [3:0]        slice_bits;

  // Ready is purely a function of the output register so a draining word and
  // a new symbol can share the same edge.
  assign bus.ready_out  = !word_valid_q || bus.ready_in;
  assign bus.signal_out = word_q;
  assign bus.valid_out  = word_valid_q;
  assign bus.error      = error_q;

  qam_slicer #(
    .SAMPLE_W     (SAMPLE_W),
    .SLICE_THRESH (SLICE_THRESH)
  ) u_slicer (
    .i_sample   (bus.signal_in[31:16]),
    .q_sample   (bus.signal_in[15:0]),
    .mode       (eff_mode),
    .slice_bits (slice_bits)
  );

  // The first symbol of a word slices with the incoming mode request; later
  // symbols use the latched mode so a word never mixes constellations.
  always_comb begin
    accept        = bus.valid_in && bus.ready_out;
    word_start    = (count == 6'd0);
    eff_mode      = word_start ? decode_mode(bus.qam) : mode_q;
    n_bits        = bits_per_symbol(eff_mode);
    count_next    = count + n_bits;
    word_done     = accept && (count_next == 6'(WORD_W));
    drain         = word_valid_q && bus.ready_in;
    illegal_start = accept && word_start && !is_legal_mode(bus.qam);
    mode_conflict = accept && !word_start && (bus.qam != 3'(mode_q));

    acc_next = acc;
    case (eff_mode)
      QAM_QPSK: acc_next = {slice_bits[1:0], acc[WORD_W-1:2]};
      QAM_16:   acc_next = {slice_bits,      acc[WORD_W-1:4]};
      default:  acc_next = {slice_bits[0],   acc[WORD_W-1:1]};
    endcase
  end

  // Accumulator, bit counter and mode latch. Shifting in at the top means the
  // first symbol of a word ends up in the lowest bits once 32 bits are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      count  <= 6'd0;
      mode_q <= QAM_BPSK;
    end else if (accept) begin
      if (word_start) begin
        mode_q <= eff_mode;
      end
      if (word_done) begin
        acc   <= '0;
        count <= 6'd0;
      end else begin
        acc   <= acc_next;
        count <= count_next;
      end
    end
  end

  // Output word register: a completing word overrides the drain so
  // back-to-back words keep valid high with fresh data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else if (word_done) begin
      word_q       <= acc_next;
      word_valid_q <= 1'b1;
    end else if (drain) begin
      word_valid_q <= 1'b0;
    end
  end

  // Sticky error: illegal mode at word start or a mode change mid-word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_q <= 1'b0;
    end else if (illegal_start || mode_conflict) begin
      error_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_qam_demod_packer.sv
// tb_qam_demod_packer
// Self-checking bench for qam_demod_packer. Expected words come from a
// reference model that decides the nearest constellation level, maps it through
// the Gray table and places each symbol's bits at its LSB-first word position.
module tb_qam_demod_packer;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  qam_demod_packer_if bus ();

  qam_demod_packer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per axis: decide level, Gray-map to {sign, mag}, return {mag, sign}.
  function automatic logic [1:0] axis_bits(input int x);
    int         level;
    logic [1:0] gray;
    if (x <= -16384)     level = -3;
    else if (x < 0)      level = -1;
    else if (x < 16384)  level = 1;
    else                 level = 3;
    case (level)
      -3:      gray = 2'b11;
      -1:      gray = 2'b10;
      1:       gray = 2'b00;
      default: gray = 2'b01;
    endcase
    return {gray[0], gray[1]};
  endfunction

  function automatic logic [3:0] ref_bits(input int i, input int q, input int mode);
    case (mode)
      1:       return {2'b00, q < 0, i < 0};
      2:       return {axis_bits(q), axis_bits(i)};
      default: return {3'b000, i < 0};
    endcase
  endfunction

  function automatic int bits_for(input int mode);
    return (mode == 1) ? 2 : (mode == 2) ? 4 : 1;
  endfunction

  // Presents one symbol and returns 1 time unit after the edge that accepts it.
  task automatic send_sym(input int i, input int q, input int m);
    int waited;
    waited        = 0;
    bus.signal_in = {16'(i), 16'(q)};
    bus.qam       = 3'(m);
    bus.valid_in  = 1'b1;
    @(negedge clk);
    while (!bus.ready_out && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.ready_out) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: ready_out=%b required 1", bus.ready_out);
    end
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
  endtask

  // kind 0: constant I/Q, kind 1: I alternates +ci/-ci, kind 2: random I/Q.
  // Symbols before change_at use qam_first, later ones qam_rest.
  task automatic run_word(input int mode, input int qam_first, input int qam_rest,
                          input int change_at, input int kind, input int ci,
                          input int cq, input string name, output logic [31:0] expw);
    int n;
    int nsym;
    int i;
    int q;
    logic [3:0] b;
    n    = bits_for(mode);
    nsym = 32 / n;
    expw = '0;
    for (int s = 0; s < nsym; s++) begin
      case (kind)
        0:       begin i = ci; q = cq; end
        1:       begin i = (s % 2 == 0) ? ci : -ci; q = cq; end
        default: begin
          i = int'($urandom_range(0, 65535)) - 32768;
          q = int'($urandom_range(0, 65535)) - 32768;
        end
      endcase
      b = ref_bits(i, q, mode);
      for (int k = 0; k < n; k++) expw[s*n+k] = b[k];
      if (s == nsym - 1) begin
        checks++;
        if (bus.valid_out !== 1'b0) begin
          failures++;
          $display("[TB] FAIL %s_early_valid: valid_out=%b required 0", name, bus.valid_out);
        end
      end
      send_sym(i, q, (s < change_at) ? qam_first : qam_rest);
    end
    checks++;
    if (bus.valid_out !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s_valid: valid_out=%b required 1", name, bus.valid_out);
    end
    checks++;
    if (bus.signal_out !== expw) begin
      failures++;
      $display("[TB] FAIL %s_word: signal_out=%h required %h", name, bus.signal_out, expw);
    end
    if (bus.ready_in) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.valid_out !== 1'b0) begin
        failures++;
        $display("[TB] FAIL %s_drain: valid_out=%b required 0", name, bus.valid_out);
      end
    end
  endtask

  task automatic check_error(input logic req, input string name);
    checks++;
    if (bus.error !== req) begin
      failures++;
      $display("[TB] FAIL %s: error=%b required %b", name, bus.error, req);
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.signal_in = '0;
    bus.qam       = 3'd0;
    bus.valid_in  = 1'b0;
    bus.ready_in  = 1'b1;
    #12;
    checks++;
    if (bus.signal_out !== 32'h0 || bus.valid_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: signal_out=%h valid_out=%b required 0/0",
               bus.signal_out, bus.valid_out);
    end
    check_error(1'b0, "reset_error");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.ready_out !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_ready: ready_out=%b required 1", bus.ready_out);
    end
  endtask

  task automatic test_modes();
    logic [31:0] w;
    run_word(0, 0, 0, 99, 1, 1000, 0, "bpsk_alt", w);
    checks++;
    if (w !== 32'hAAAAAAAA) begin
      failures++;
      $display("[TB] FAIL bpsk_model: model=%h required aaaaaaaa", w);
    end
    run_word(1, 1, 1, 99, 0, -100, 100, "qpsk", w);
    run_word(2, 2, 2, 99, 0, 24576, -8192, "qam16", w);
    check_error(1'b0, "modes_error");
  endtask

  task automatic test_boundaries();
    logic [31:0] w;
    run_word(2, 2, 2, 99, 0, 16384, -32768, "bound_outer", w);
    run_word(2, 2, 2, 99, 0, 0, 16383, "bound_zero", w);
    run_word(2, 2, 2, 99, 0, -16384, 16384, "bound_neg", w);
    run_word(2, 2, 2, 99, 0, -16383, 32767, "bound_inner", w);
  endtask

  task automatic test_random();
    logic [31:0] w;
    int m;
    for (int r = 0; r < 6; r++) begin
      m = int'($urandom_range(0, 2));
      run_word(m, m, m, 99, 2, 0, 0, "random", w);
    end
    check_error(1'b0, "random_error");
  endtask

  task automatic test_backpressure();
    logic [31:0] w;
    bus.ready_in = 1'b0;
    run_word(0, 0, 0, 99, 2, 0, 0, "bp_word", w);
    bus.signal_in = {16'hFFFF, 16'h0000};
    bus.qam       = 3'd0;
    bus.valid_in  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.ready_out !== 1'b0 || bus.valid_out !== 1'b1 || bus.signal_out !== w) begin
        failures++;
        $display("[TB] FAIL bp_hold: ready_out=%b valid_out=%b signal_out=%h required 0/1/%h",
                 bus.ready_out, bus.valid_out, bus.signal_out, w);
      end
    end
    @(negedge clk);
    bus.ready_in = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    checks++;
    if (bus.valid_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_drain: valid_out=%b required 0", bus.valid_out);
    end
    // The I=-1 symbol must have been taken exactly once, on the drain edge.
    for (int s = 0; s < 31; s++) send_sym(5, 0, 0);
    checks++;
    if (bus.valid_out !== 1'b1 || bus.signal_out !== 32'h00000001) begin
      failures++;
      $display("[TB] FAIL bp_same_cycle_accept: valid_out=%b signal_out=%h required 1/00000001",
               bus.valid_out, bus.signal_out);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_mode_change();
    logic [31:0] w;
    run_word(1, 1, 2, 3, 2, 0, 0, "mode_change", w);
    check_error(1'b1, "mode_change_error");
    run_word(0, 5, 5, 99, 0, -1, 0, "illegal_mode", w);
    check_error(1'b1, "illegal_mode_error");
  endtask

  task automatic test_async_reset();
    logic [31:0] w;
    for (int s = 0; s < 10; s++) send_sym(1, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.signal_out !== 32'h0 || bus.valid_out !== 1'b0 || bus.ready_out !== 1'b1) begin
      failures++;
      $display("[TB] FAIL async_reset: signal_out=%h valid_out=%b ready_out=%b required 0/0/1",
               bus.signal_out, bus.valid_out, bus.ready_out);
    end
    check_error(1'b0, "async_reset_error");
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_word(0, 0, 0, 99, 0, -1, 0, "post_reset", w);
    check_error(1'b0, "post_reset_error");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_modes();
    test_boundaries();
    test_random();
    test_backpressure();
    test_mode_change();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
